// File: rtl/text_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package text_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam int         LEN_BYTES      = 2;
    localparam logic [7:0] CHECKSUM_INIT  = 8'h00;

endpackage

// File: rtl/text_loader_word_packer.sv
// Little-endian byte-to-word assembler with a one-cycle word-complete pulse.
// The completed word is latched separately so it stays stable while the
// next word is being shifted in.
module word_packer
    import text_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_en_i,
    output logic [DATA_WIDTH-1:0] word_out_o,
    output logic                  word_done_o
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  done_q;

    // First byte ends up in bits 7:0 after a full word has been shifted in
    assign shift_d = {byte_in_i, shift_q[DATA_WIDTH-1:8]};

    // Byte counting, shifting, and completion pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear_i) begin
                cnt_q   <= '0;
                shift_q <= '0;
            end else if (byte_en_i) begin
                shift_q <= shift_d;
                if (cnt_q == CW'(BYTES_PER_WORD - 1)) begin
                    cnt_q  <= '0;
                    word_q <= shift_d;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign word_out_o  = word_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/text_loader.sv
// Framed byte-stream loader for the core's instruction memory. Parses a
// 16-bit word count, writes little-endian words from address 0 upwards,
// verifies an XOR checksum and holds the core in reset while loading.
module text_loader
    import text_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  core_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int                HDR_BITS  = 8 * LEN_BYTES;
    localparam int                IW        = ADDR_WIDTH + 1;
    localparam logic [HDR_BITS-1:0] MAX_WORDS = HDR_BITS'(2 ** ADDR_WIDTH);

    state_e                state_q;
    logic [7:0]            len_lo_q;
    logic [IW-1:0]         len_q;
    logic [IW-1:0]         idx_q;
    logic [1:0]            pos_q;
    logic [7:0]            chk_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  byte_ready_q;
    logic                  core_hold_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic                  start_ok;
    logic [HDR_BITS-1:0]   hdr_len;
    logic                  word_last;
    logic                  frame_last;

    assign accept     = byte_valid_i && byte_ready_q;
    assign start_ok   = start_i && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign hdr_len    = {byte_data_i, len_lo_q};
    // Index width has one spare bit so a full-capacity frame never wraps
    assign word_last  = (pos_q == 2'(BYTES_PER_WORD - 1));
    assign frame_last = word_last && ((idx_q + IW'(1)) == len_q);

    word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_ok),
        .byte_in_i   (byte_data_i),
        .byte_en_i   (accept && state_q == ST_DATA),
        .word_out_o  (mem_wdata_o),
        .word_done_o (mem_we_o)
    );

    // Frame FSM; ready/hold are registered alongside each state change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            pos_q        <= '0;
            chk_q        <= CHECKSUM_INIT;
            mem_addr_q   <= '0;
            byte_ready_q <= 1'b0;
            core_hold_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_q      <= ST_LEN_LO;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        idx_q        <= '0;
                        pos_q        <= '0;
                        chk_q        <= CHECKSUM_INIT;
                        byte_ready_q <= 1'b1;
                        core_hold_q  <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo_q <= byte_data_i;
                        state_q  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q <= hdr_len[IW-1:0];
                        if (hdr_len == '0) begin
                            state_q <= ST_CHECK;
                        end else if (hdr_len > MAX_WORDS) begin
                            state_q      <= ST_ERR;
                            error_q      <= 1'b1;
                            byte_ready_q <= 1'b0;
                            core_hold_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        chk_q <= chk_q ^ byte_data_i;
                        pos_q <= pos_q + 2'd1;
                        if (word_last) begin
                            mem_addr_q <= idx_q[ADDR_WIDTH-1:0];
                            idx_q      <= idx_q + IW'(1);
                            if (frame_last) state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        core_hold_q  <= 1'b0;
                        if (byte_data_i == chk_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    core_hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_addr_o   = mem_addr_q;
    assign core_hold_o  = core_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
